// File: rtl/register_store_unit_if.sv
// Bus bundle between a register store unit and its source register, address
// register and byte-wide memory.
interface register_store_unit_if #(
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  Start;
    logic [15:0]           Data;
    logic [ADDR_WIDTH-1:0] Addr;
    logic [ADDR_WIDTH-1:0] MemAddr;
    logic [7:0]            MemData;
    logic                  MemWE;
    logic                  MemReady;
    logic [1:0]            ARFunSel;
    logic                  AREnable;
    logic                  Busy;
    logic                  Done;

    // Store unit side
    modport slave (
        input  Start, Data, Addr, MemReady,
        output MemAddr, MemData, MemWE, ARFunSel, AREnable, Busy, Done
    );

    // Requester / memory / address-register side
    modport master (
        output Start, Data, Addr, MemReady,
        input  MemAddr, MemData, MemWE, ARFunSel, AREnable, Busy, Done
    );
endinterface

// File: rtl/register_store_unit.sv
// Stores a 16-bit register value to byte-wide memory as two handshaked byte
// writes, pulsing address-register increments for each accepted byte.
module register_store_unit #(
    parameter bit          BIG_ENDIAN = 1'b0,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    register_store_unit_if.slave  bus
);

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned BYTE_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR0  = 2'd1,
        WR1  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [DATA_WIDTH-1:0]   d_q;
    logic [DATA_WIDTH-1:0]   d_nx;
    logic [ADDR_WIDTH-1:0]   a_q;
    logic [ADDR_WIDTH-1:0]   a_nx;

    logic                    mem_we_nx;
    logic                    busy_nx;
    logic                    done_nx;
    logic [ADDR_WIDTH-1:0]   mem_addr_nx;
    logic [BYTE_WIDTH-1:0]   mem_data_nx;
    logic [BYTE_WIDTH-1:0]   first_byte;
    logic [BYTE_WIDTH-1:0]   second_byte;
    logic                    writing;

    // Next state and capture; Start is only honoured in IDLE
    always_comb begin
        state_nx = state;
        d_nx     = d_q;
        a_nx     = a_q;
        unique case (state)
            IDLE: begin
                if (bus.Start) begin
                    state_nx = WR0;
                    d_nx     = bus.Data;
                    a_nx     = bus.Addr;
                end
            end
            WR0: begin
                if (bus.MemReady) state_nx = WR1;
            end
            WR1: begin
                if (bus.MemReady) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Byte order of the stored word
    always_comb begin
        first_byte  = d_nx[BYTE_WIDTH-1:0];
        second_byte = d_nx[DATA_WIDTH-1:BYTE_WIDTH];
        if (BIG_ENDIAN) begin
            first_byte  = d_nx[DATA_WIDTH-1:BYTE_WIDTH];
            second_byte = d_nx[BYTE_WIDTH-1:0];
        end
    end

    // Output values for the upcoming state, so memory-side outputs are registered
    always_comb begin
        mem_we_nx   = 1'b0;
        busy_nx     = 1'b0;
        done_nx     = 1'b0;
        mem_addr_nx = '0;
        mem_data_nx = '0;
        unique case (state_nx)
            WR0: begin
                mem_we_nx   = 1'b1;
                busy_nx     = 1'b1;
                mem_addr_nx = a_nx;
                mem_data_nx = first_byte;
            end
            WR1: begin
                mem_we_nx   = 1'b1;
                busy_nx     = 1'b1;
                mem_addr_nx = a_nx + ADDR_WIDTH'(1);
                mem_data_nx = second_byte;
            end
            DONE: begin
                done_nx = 1'b1;
            end
            default: begin
                mem_we_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            d_q         <= '0;
            a_q         <= '0;
            bus.MemWE   <= 1'b0;
            bus.Busy    <= 1'b0;
            bus.Done    <= 1'b0;
            bus.MemAddr <= '0;
            bus.MemData <= '0;
        end else begin
            state       <= state_nx;
            d_q         <= d_nx;
            a_q         <= a_nx;
            bus.MemWE   <= mem_we_nx;
            bus.Busy    <= busy_nx;
            bus.Done    <= done_nx;
            bus.MemAddr <= mem_addr_nx;
            bus.MemData <= mem_data_nx;
        end
    end

    // Increment pulse on each accepted byte; reset suppresses it
    assign writing      = (state == WR0) || (state == WR1);
    assign bus.AREnable = writing && bus.MemReady && !Reset;
    assign bus.ARFunSel = bus.AREnable ? 2'b01 : 2'b00;

endmodule
